// File: rtl/cond_filter_bank.sv
// rtl/cond_filter_bank.sv - per-channel registered condition F, symmetric debounce and saturating rise counters
// Optional per-channel masking of the raw condition is enabled by COND_FILTER_BANK_MASK_EN.
module cond_filter_bank #(
    parameter int CH    = 4,
    parameter int HOLD  = 3,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [4*CH-1:0]     in_abcd,
    input  logic                clr_cnt,
`ifdef COND_FILTER_BANK_MASK_EN
    input  logic [CH-1:0]       ch_mask,
`endif
    output logic                raw_valid,
    output logic [CH-1:0]       raw_f,
    output logic                flt_valid,
    output logic [CH-1:0]       flt_f,
    output logic [CNT_W*CH-1:0] rise_cnt
);

    localparam int DC_W = $clog2(HOLD) + 1;
    localparam logic [DC_W-1:0]  DC_LAST = DC_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic cond_f(input logic [3:0] s);
        return (s[3] & ~s[2]) | (~s[3] & s[2] & (s[1] | s[0]));
    endfunction

    logic [CH-1:0] mask_eff;
`ifdef COND_FILTER_BANK_MASK_EN
    assign mask_eff = ch_mask;
`else
    assign mask_eff = '0;
`endif

    logic [CH-1:0] f_comb;

    always_comb begin
        f_comb = '0;
        for (int i = 0; i < CH; i++) begin
            f_comb[i] = cond_f(in_abcd[4*i +: 4]) & ~mask_eff[i];
        end
    end

    // dc_q counts consecutive valid samples where raw_f disagrees with flt_f
    logic [DC_W-1:0]     dc_q [CH];
    logic [DC_W-1:0]     dc_d [CH];
    logic [CH-1:0]       flt_d;
    logic [CNT_W*CH-1:0] cnt_d;

    always_comb begin
        logic             rise;
        logic [CNT_W-1:0] c;
        flt_d = flt_f;
        cnt_d = rise_cnt;
        rise  = 1'b0;
        c     = '0;
        for (int i = 0; i < CH; i++) begin
            dc_d[i] = dc_q[i];
            rise    = 1'b0;
            if (raw_valid) begin
                if (raw_f[i] == flt_f[i]) begin
                    dc_d[i] = '0;
                end else if (dc_q[i] == DC_LAST) begin
                    flt_d[i] = raw_f[i];
                    dc_d[i]  = '0;
                    rise     = raw_f[i];
                end else begin
                    dc_d[i] = dc_q[i] + 1'b1;
                end
            end
            // clear dominates a coincident rise
            c = rise_cnt[CNT_W*i +: CNT_W];
            if (clr_cnt) begin
                c = '0;
            end else if (rise && (c != CNT_MAX)) begin
                c = c + 1'b1;
            end
            cnt_d[CNT_W*i +: CNT_W] = c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_valid <= 1'b0;
            raw_f     <= '0;
            flt_valid <= 1'b0;
            flt_f     <= '0;
            rise_cnt  <= '0;
            for (int i = 0; i < CH; i++) begin
                dc_q[i] <= '0;
            end
        end else begin
            raw_valid <= in_valid;
            if (in_valid) begin
                raw_f <= f_comb;
            end
            flt_valid <= raw_valid;
            flt_f     <= flt_d;
            rise_cnt  <= cnt_d;
            for (int i = 0; i < CH; i++) begin
                dc_q[i] <= dc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cond_filter_bank.sv
// tb/tb_cond_filter_bank.sv - bench for cond_filter_bank with a history-window reference model
module tb_cond_filter_bank;

    localparam int CH     = 4;
    localparam int HOLD_A = 3;
    localparam int CNTW_A = 8;
    localparam int HOLD_B = 1;
    localparam int CNTW_B = 2;
    // F=1 for codes 5,6,7,8,9,10,11
    localparam logic [15:0] F_TAB = 16'h0FE0;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [4*CH-1:0]   in_abcd;
    logic              clr_cnt;
    logic [CH-1:0]     ch_mask;

    logic              a_raw_valid, a_flt_valid;
    logic [CH-1:0]     a_raw_f, a_flt_f;
    logic [CNTW_A*CH-1:0] a_rise_cnt;
    logic              b_raw_valid, b_flt_valid;
    logic [CH-1:0]     b_raw_f, b_flt_f;
    logic [CNTW_B*CH-1:0] b_rise_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cond_filter_bank #(.CH(CH), .HOLD(HOLD_A), .CNT_W(CNTW_A)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_abcd(in_abcd), .clr_cnt(clr_cnt),
`ifdef COND_FILTER_BANK_MASK_EN
        .ch_mask(ch_mask),
`endif
        .raw_valid(a_raw_valid), .raw_f(a_raw_f), .flt_valid(a_flt_valid),
        .flt_f(a_flt_f), .rise_cnt(a_rise_cnt)
    );

    cond_filter_bank #(.CH(CH), .HOLD(HOLD_B), .CNT_W(CNTW_B)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_abcd(in_abcd), .clr_cnt(clr_cnt),
`ifdef COND_FILTER_BANK_MASK_EN
        .ch_mask(ch_mask),
`endif
        .raw_valid(b_raw_valid), .raw_f(b_raw_f), .flt_valid(b_flt_valid),
        .flt_f(b_flt_f), .rise_cnt(b_rise_cnt)
    );

    // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
    // The filter flips when the last HOLD valid raw samples all differ from it.
    bit            m_rv [2];
    logic [CH-1:0] m_rf [2];
    bit            m_fv [2];
    logic [CH-1:0] m_flt [2];
    int            m_cnt [2][CH];
    logic [31:0]   m_hist [2][CH];

    function automatic logic f_ref(input logic [3:0] code);
        return F_TAB[code];
    endfunction

    task automatic model_clk();
        for (int k = 0; k < 2; k++) begin
            int          hold;
            int          cmax;
            logic [31:0] win;
            bit          rose;
            hold = (k == 0) ? HOLD_A : HOLD_B;
            cmax = (k == 0) ? (1 << CNTW_A) - 1 : (1 << CNTW_B) - 1;
            win  = (32'd1 << hold) - 32'd1;
            if (rst) begin
                m_rv[k] = 0; m_rf[k] = '0; m_fv[k] = 0; m_flt[k] = '0;
                for (int i = 0; i < CH; i++) begin
                    m_cnt[k][i] = 0;
                    m_hist[k][i] = '0;
                end
            end else begin
                for (int i = 0; i < CH; i++) begin
                    rose = 0;
                    if (m_rv[k]) begin
                        m_hist[k][i] = {m_hist[k][i][30:0], m_rf[k][i]};
                        if ((m_hist[k][i] & win) == (m_flt[k][i] ? 32'd0 : win)) begin
                            rose = !m_flt[k][i];
                            m_flt[k][i] = ~m_flt[k][i];
                        end
                    end
                    if (clr_cnt) m_cnt[k][i] = 0;
                    else if (rose && m_cnt[k][i] < cmax) m_cnt[k][i] = m_cnt[k][i] + 1;
                end
                m_fv[k] = m_rv[k];
                m_rv[k] = in_valid;
                if (in_valid) begin
                    for (int i = 0; i < CH; i++) m_rf[k][i] = f_ref(in_abcd[4*i +: 4]) & ~ch_mask[i];
                end
            end
        end
    endtask

    function automatic logic [CNTW_A*CH-1:0] pack_a();
        logic [CNTW_A*CH-1:0] r;
        for (int i = 0; i < CH; i++) r[CNTW_A*i +: CNTW_A] = CNTW_A'(m_cnt[0][i]);
        return r;
    endfunction

    function automatic logic [CNTW_B*CH-1:0] pack_b();
        logic [CNTW_B*CH-1:0] r;
        for (int i = 0; i < CH; i++) r[CNTW_B*i +: CNTW_B] = CNTW_B'(m_cnt[1][i]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_clk();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0; in_abcd = '0; ch_mask = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; clr_cnt = 1'b0; ch_mask = '0; in_abcd = 16'($urandom);
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if ({a_raw_valid, a_raw_f, a_flt_valid, a_flt_f, a_rise_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_a: got %b %b %b %b %h want all zero", a_raw_valid, a_raw_f, a_flt_valid, a_flt_f, a_rise_cnt);
        end
        checks++;
        if ({b_raw_valid, b_raw_f, b_flt_valid, b_flt_f, b_rise_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_b: got %b %b %b %b %h want all zero", b_raw_valid, b_raw_f, b_flt_valid, b_flt_f, b_rise_cnt);
        end
    endtask

    task automatic test_truth_table();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            for (int i = 0; i < CH; i++) in_abcd[4*i +: 4] = 4'(4*k + i);
            tick();
            checks++;
            if (a_raw_valid !== 1'b1) begin
                errors++;
                $display("FAIL truth_raw_valid k=%0d: got %b want 1", k, a_raw_valid);
            end
            for (int i = 0; i < CH; i++) begin
                checks++;
                if (a_raw_f[i] !== F_TAB[4*k + i] || b_raw_f[i] !== F_TAB[4*k + i]) begin
                    errors++;
                    $display("FAIL truth code=%0d: got a=%b b=%b want %b", 4*k + i, a_raw_f[i], b_raw_f[i], F_TAB[4*k + i]);
                end
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_debounce();
        bit s [12]       = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0};
        bit exp_flt [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        do_reset();
        for (int j = 0; j < 13; j++) begin
            in_valid = (j < 12);
            in_abcd  = '0;
            if (j < 12 && s[j]) in_abcd[3:0] = 4'b1000;
            tick();
            checks++;
            if (a_flt_f[0] !== exp_flt[j]) begin
                errors++;
                $display("FAIL debounce_flt tick=%0d: got %b want %b", j, a_flt_f[0], exp_flt[j]);
            end
            checks++;
            if (a_rise_cnt !== pack_a() || a_flt_valid !== m_fv[0]) begin
                errors++;
                $display("FAIL debounce_cnt tick=%0d: got %h/%b want %h/%b", j, a_rise_cnt, a_flt_valid, pack_a(), m_fv[0]);
            end
        end
        checks++;
        if (a_rise_cnt[7:0] !== 8'd1) begin
            errors++;
            $display("FAIL debounce_final_cnt: got %0d want 1", a_rise_cnt[7:0]);
        end
    endtask

    task automatic test_valid_gaps();
        bit v [8]       = '{1, 0, 0, 1, 0, 1, 0, 0};
        bit exp_flt [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
        do_reset();
        for (int j = 0; j < 8; j++) begin
            in_valid = v[j];
            in_abcd  = v[j] ? 16'h0008 : 16'($urandom);
            tick();
            checks++;
            if (a_flt_f[0] !== exp_flt[j] || a_rise_cnt[7:0] !== 8'(exp_flt[j])) begin
                errors++;
                $display("FAIL gaps tick=%0d: got flt=%b cnt=%0d want flt=%b cnt=%0d", j, a_flt_f[0], a_rise_cnt[7:0], exp_flt[j], exp_flt[j]);
            end
            checks++;
            if (a_raw_f !== m_rf[0] || b_raw_f !== m_rf[1]) begin
                errors++;
                $display("FAIL gaps_raw tick=%0d: got %b/%b want %b/%b", j, a_raw_f, b_raw_f, m_rf[0], m_rf[1]);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        do_reset();
        for (int r = 0; r < 5; r++) begin
            in_valid = 1'b1; in_abcd = 16'h0080;
            tick();
            in_abcd = 16'h0000;
            tick();
            checks++;
            if (b_rise_cnt[3:2] !== 2'(exp_cnt[r]) || b_flt_f[1] !== 1'b1) begin
                errors++;
                $display("FAIL saturation r=%0d: got cnt=%0d flt=%b want cnt=%0d flt=1", r, b_rise_cnt[3:2], b_flt_f[1], exp_cnt[r]);
            end
            checks++;
            if (b_rise_cnt !== pack_b() || a_rise_cnt !== pack_a()) begin
                errors++;
                $display("FAIL saturation_model r=%0d: got %h/%h want %h/%h", r, b_rise_cnt, a_rise_cnt, pack_b(), pack_a());
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_clr_coincide();
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 6; j++) begin
                in_valid = 1'b1;
                in_abcd  = (j < 3) ? 16'h0800 : 16'h0000;
                tick();
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (a_rise_cnt[23:16] !== 8'd5 || a_flt_f[2] !== 1'b0) begin
            errors++;
            $display("FAIL clr_setup: got cnt=%0d flt=%b want cnt=5 flt=0", a_rise_cnt[23:16], a_flt_f[2]);
        end
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_abcd = 16'h0800;
            tick();
        end
        in_valid = 1'b0; clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (a_rise_cnt[23:16] !== 8'd0 || a_flt_f[2] !== 1'b1) begin
            errors++;
            $display("FAIL clr_coincide: got cnt=%0d flt=%b want cnt=0 flt=1", a_rise_cnt[23:16], a_flt_f[2]);
        end
        checks++;
        if (a_rise_cnt !== pack_a() || b_rise_cnt !== pack_b()) begin
            errors++;
            $display("FAIL clr_model: got %h/%h want %h/%h", a_rise_cnt, b_rise_cnt, pack_a(), pack_b());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_abcd = 16'h0008;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({a_raw_valid, a_raw_f, a_flt_valid, a_flt_f, a_rise_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %b %b %b %b %h want all zero", a_raw_valid, a_raw_f, a_flt_valid, a_flt_f, a_rise_cnt);
        end
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (a_flt_f[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_two: got flt=%b want 0", a_flt_f[0]);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (a_flt_f[0] !== 1'b1 || a_rise_cnt[7:0] !== 8'd1) begin
            errors++;
            $display("FAIL reset_mid_three: got flt=%b cnt=%0d want flt=1 cnt=1", a_flt_f[0], a_rise_cnt[7:0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_abcd  = 16'($urandom);
            clr_cnt  = ($urandom_range(0, 24) == 0);
            rst      = ($urandom_range(0, 149) == 0);
`ifdef COND_FILTER_BANK_MASK_EN
            ch_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
`endif
            tick();
            checks++;
            if ({a_raw_valid, a_raw_f, a_flt_valid, a_flt_f, a_rise_cnt} !== {m_rv[0], m_rf[0], m_fv[0], m_flt[0], pack_a()}) begin
                errors++;
                $display("FAIL random_a n=%0d: got %b %b %b %b %h want %b %b %b %b %h", n,
                         a_raw_valid, a_raw_f, a_flt_valid, a_flt_f, a_rise_cnt, m_rv[0], m_rf[0], m_fv[0], m_flt[0], pack_a());
            end
            checks++;
            if ({b_raw_valid, b_raw_f, b_flt_valid, b_flt_f, b_rise_cnt} !== {m_rv[1], m_rf[1], m_fv[1], m_flt[1], pack_b()}) begin
                errors++;
                $display("FAIL random_b n=%0d: got %b %b %b %b %h want %b %b %b %b %h", n,
                         b_raw_valid, b_raw_f, b_flt_valid, b_flt_f, b_rise_cnt, m_rv[1], m_rf[1], m_fv[1], m_flt[1], pack_b());
            end
        end
        rst = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0; ch_mask = '0;
    endtask

`ifdef COND_FILTER_BANK_MASK_EN
    task automatic test_mask();
        do_reset();
        ch_mask = 4'b0001;
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1;
            in_abcd  = {12'($urandom), 4'b1000};
            tick();
            checks++;
            if (a_raw_f[0] !== 1'b0 || a_rise_cnt[7:0] !== 8'd0) begin
                errors++;
                $display("FAIL mask_ch0 j=%0d: got raw=%b cnt=%0d want raw=0 cnt=0", j, a_raw_f[0], a_rise_cnt[7:0]);
            end
            checks++;
            if (a_raw_f !== m_rf[0] || a_flt_f !== m_flt[0] || a_rise_cnt !== pack_a()) begin
                errors++;
                $display("FAIL mask_model j=%0d: got %b %b %h want %b %b %h", j, a_raw_f, a_flt_f, a_rise_cnt, m_rf[0], m_flt[0], pack_a());
            end
        end
        ch_mask = '0;
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_abcd = '0; clr_cnt = 1'b0; ch_mask = '0;
        test_reset();
        test_truth_table();
        test_debounce();
        test_valid_gaps();
        test_saturation();
        test_clr_coincide();
        test_reset_mid();
`ifdef COND_FILTER_BANK_MASK_EN
        test_mask();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
